// File: rtl/dff_sync_clear_pkg.sv
// rtl/dff_sync_clear_pkg.sv - shared defaults for the clearable flop bank
package dff_sync_clear_pkg;

  // A single flop unless the instantiating register bank asks for more.
  localparam int DFF_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/dff_sync_clear.sv
// rtl/dff_sync_clear.sv - D flop bank with synchronous active-high clear and complementary outputs
module dff_sync_clear
  import dff_sync_clear_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

  // qb comes straight off the one q register so the pair can never disagree.
  assign qb = ~q;

endmodule

// File: tb/tb_dff_sync_clear.sv
// tb/tb_dff_sync_clear.sv - randomized bench for dff_sync_clear against a behavioural model
module tb_dff_sync_clear;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [0:0] d1 = '0;
  logic [0:0] q1;
  logic [0:0] qb1;
  logic [7:0] d8 = '0;
  logic [7:0] q8;
  logic [7:0] qb8;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: what q should currently hold, or unknown before the first edge.
  logic [0:0] exp1;
  logic [7:0] exp8;
  bit         primed = 0;

  always #5 clk = ~clk;

  dff_sync_clear u_dut1 (
    .clk   (clk),
    .clear (clear),
    .d     (d1),
    .q     (q1),
    .qb    (qb1)
  );

  dff_sync_clear #(
    .WIDTH       (8),
    .RESET_VALUE (RV8)
  ) u_dut8 (
    .clk   (clk),
    .clear (clear),
    .d     (d8),
    .q     (q8),
    .qb    (qb8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q1"}, {7'b0, q1}, {7'b0, exp1});
    check({tag, "_qb1"}, {7'b0, qb1}, {7'b0, ~exp1});
    check({tag, "_q8"}, q8, exp8);
    check({tag, "_qb8"}, qb8, ~exp8);
  endtask

  // Inputs change on the falling edge; between edges the outputs must still
  // show the previous capture, then the model's new value just after the edge.
  task automatic do_cycle(input string tag, input logic c, input logic [0:0] dv1,
                          input logic [7:0] dv8);
    @(negedge clk);
    clear = c;
    d1    = dv1;
    d8    = dv8;
    #1;
    if (primed) check_all({tag, "_between"});
    @(posedge clk);
    exp1   = c ? 1'b0 : dv1;
    exp8   = c ? RV8 : dv8;
    primed = 1;
    #1;
    check_all(tag);
  endtask

  initial begin
    // Clear from time zero; first edge lands at t=5.
    d1 = 1'b1;
    d8 = 8'h3C;
    @(posedge clk);
    exp1   = 1'b0;
    exp8   = RV8;
    primed = 1;
    #1;
    check_all("reset_edge1");
    do_cycle("reset_edge2", 1'b1, 1'b0, 8'hFF);
    do_cycle("reset_edge3", 1'b1, 1'b1, 8'h00);

    // Capture sequence 1,0,1,0,1.
    for (int i = 0; i < 5; i++) begin
      do_cycle("capture", 1'b0, ((i % 2) == 0) ? 1'b1 : 1'b0, (i % 2 == 0) ? 8'h3C : 8'hC3);
    end

    // Mid-cycle clear: q holds 1 until the edge, then clears; release with d=1.
    do_cycle("sync_clear", 1'b1, 1'b1, 8'h77);
    do_cycle("clear_release", 1'b0, 1'b1, 8'h3C);

    // Priority of clear over d, then hold d=1 for 10 edges.
    do_cycle("priority", 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      do_cycle("hold", 1'b0, 1'b1, 8'h3C);
    end

    // Random traffic with occasional single-cycle clears.
    for (int i = 0; i < 200; i++) begin
      do_cycle("random", ($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the bench always reaches its summary.
  initial begin
    #100000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
